// File: rtl/measdif_axil_regs_if.sv
// AXI4-Lite bus bundle for the measdif S00_AXI register port.
interface measdif_axil_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/measdif_axil_regs.sv
// measdif AXI4-Lite register bank with an evt_a->evt_b interval-measurement FSM.
// Optional feature: define MEASDIF_IRQ_EN to get a registered done interrupt gated by CTRL[2].
module measdif_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic               s00_axi_aclk,
    input  logic               s00_axi_aresetn,
    measdif_axil_regs_if.slave s00_axi,
    input  logic               evt_a,
    input  logic               evt_b,
    output logic               irq
);
    typedef enum logic [1:0] {IDLE, ARMED, COUNT, DONE} state_t;

    state_t                          state;
    logic                            live;
    logic                            aw_full;
    logic                            w_full;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_q;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb_q;
    logic                            bvalid;
    logic                            rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic                            enable;
    logic                            arm;
    logic                            irq_en;
    logic [C_S_AXI_DATA_WIDTH-1:0]   scratch;
    logic [C_CNT_WIDTH-1:0]          cnt;
    logic [C_CNT_WIDTH-1:0]          diff;
    logic                            done;
    logic                            ovf;
    logic                            evt_a_q;
    logic                            evt_b_q;

    logic                            busy;
    logic                            rise_a;
    logic                            rise_b;
    logic                            aw_hs;
    logic                            w_hs;
    logic                            ar_hs;
    logic                            do_write;
    logic [C_S_AXI_DATA_WIDTH-1:0]   diff_ext;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rd_mux;
    logic                            unused_bits;

    assign busy     = (state == ARMED) || (state == COUNT);
    assign rise_a   = evt_a & ~evt_a_q;
    assign rise_b   = evt_b & ~evt_b_q;
    assign aw_hs    = s00_axi.awvalid & s00_axi.awready;
    assign w_hs     = s00_axi.wvalid & s00_axi.wready;
    assign ar_hs    = s00_axi.arvalid & s00_axi.arready;
    assign do_write = aw_full & w_full;

    // 'live' keeps every ready low while reset is held and for the first cycle after it.
    assign s00_axi.awready = live & ~aw_full & ~bvalid;
    assign s00_axi.wready  = live & ~w_full & ~bvalid;
    assign s00_axi.arready = live & ~rvalid;
    assign s00_axi.bvalid  = bvalid;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.rvalid  = rvalid;
    assign s00_axi.rdata   = rdata;
    assign s00_axi.rresp   = 2'b00;

    assign unused_bits = ^{aw_addr_q[1:0], s00_axi.araddr[1:0], s00_axi.awprot, s00_axi.arprot};

`ifndef MEASDIF_IRQ_EN
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        diff_ext = '0;
        diff_ext[C_CNT_WIDTH-1:0] = diff;
    end

    always_comb begin
        rd_mux = '0;
        case (s00_axi.araddr[3:2])
            2'd0:    rd_mux[2:0] = {irq_en, arm, enable};
            2'd1:    rd_mux = scratch;
            2'd2:    rd_mux = diff_ext;
            default: rd_mux[2:0] = {busy, ovf, done};
        endcase
    end

    // Register writes come before the FSM so that a same-cycle done/ovf set overrides the W1C clear.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state     <= IDLE;
            live      <= 1'b0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            enable    <= 1'b0;
            arm       <= 1'b0;
            scratch   <= '0;
            cnt       <= '0;
            diff      <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            evt_a_q   <= 1'b0;
            evt_b_q   <= 1'b0;
        end else begin
            live    <= 1'b1;
            evt_a_q <= evt_a;
            evt_b_q <= evt_b;
            arm     <= 1'b0;

            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= s00_axi.awaddr;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= s00_axi.wdata;
                w_strb_q <= s00_axi.wstrb;
            end

            if (do_write) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                case (aw_addr_q[3:2])
                    2'd0: if (w_strb_q[0]) begin
                        enable <= w_data_q[0];
                        arm    <= w_data_q[1];
                    end
                    2'd1: for (int i = 0; i < C_S_AXI_DATA_WIDTH / 8; i++) begin
                        if (w_strb_q[i]) scratch[8*i +: 8] <= w_data_q[8*i +: 8];
                    end
                    2'd3: if (w_strb_q[0]) begin
                        if (w_data_q[0]) done <= 1'b0;
                        if (w_data_q[1]) ovf  <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (bvalid && s00_axi.bready) begin
                bvalid <= 1'b0;
            end

            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_mux;
            end else if (rvalid && s00_axi.rready) begin
                rvalid <= 1'b0;
            end

            if (busy && !enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:  if (arm && enable) state <= ARMED;
                    ARMED: if (rise_a) begin
                        state <= COUNT;
                        cnt   <= C_CNT_WIDTH'(1);
                    end
                    COUNT: if (rise_b) begin
                        diff  <= cnt;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (&cnt) begin
                        ovf <= 1'b1;
                    end else begin
                        cnt <= cnt + C_CNT_WIDTH'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef MEASDIF_IRQ_EN
    logic irq_q;

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (do_write && aw_addr_q[3:2] == 2'd0 && w_strb_q[0]) irq_en <= w_data_q[2];
            irq_q <= done & irq_en;
        end
    end

    assign irq = irq_q;
`endif
endmodule

// File: tb/tb_measdif_axil_regs.sv
// Directed self-checking bench for measdif_axil_regs; a second instance with a 4-bit counter shadows the bus.
module tb_measdif_axil_regs;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic evt_a = 1'b0;
    logic evt_b = 1'b0;
    logic irq;
    logic irq4;
    int   checks = 0;
    int   failures = 0;

`ifdef MEASDIF_IRQ_EN
    localparam logic IRQ_BUILD = 1'b1;
`else
    localparam logic IRQ_BUILD = 1'b0;
`endif

    measdif_axil_regs_if bus ();
    measdif_axil_regs_if bus4 ();

    measdif_axil_regs dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rstn), .s00_axi(bus),
        .evt_a(evt_a), .evt_b(evt_b), .irq(irq)
    );

    measdif_axil_regs #(.C_CNT_WIDTH(4)) dut4 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rstn), .s00_axi(bus4),
        .evt_a(evt_a), .evt_b(evt_b), .irq(irq4)
    );

    // The narrow-counter instance sees exactly the same master traffic.
    assign bus4.awaddr  = bus.awaddr;
    assign bus4.awprot  = bus.awprot;
    assign bus4.awvalid = bus.awvalid;
    assign bus4.wdata   = bus.wdata;
    assign bus4.wstrb   = bus.wstrb;
    assign bus4.wvalid  = bus.wvalid;
    assign bus4.bready  = bus.bready;
    assign bus4.araddr  = bus.araddr;
    assign bus4.arprot  = bus.arprot;
    assign bus4.arvalid = bus.arvalid;
    assign bus4.rready  = bus.rready;

    always #5 clk = ~clk;

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, input int w_delay, input int bhold,
                             output logic [1:0] resp, output int n_b, output int bv_cycles);
        bit aw_done;
        bit w_done;
        int hold;
        aw_done = 0;
        w_done = 0;
        hold = 0;
        resp = 2'bxx;
        n_b = 0;
        bv_cycles = 0;
        bus.awaddr = addr;
        bus.wdata = data;
        bus.wstrb = strb;
        for (int c = 0; c < 20; c++) begin
            bus.awvalid = !aw_done && (c >= aw_delay);
            bus.wvalid = !w_done && (c >= w_delay);
            bus.bready = 1'b0;
            if (bus.bvalid) begin
                bv_cycles++;
                if (hold >= bhold) begin
                    bus.bready = 1'b1;
                    n_b++;
                    resp = bus.bresp;
                end else begin
                    hold++;
                end
            end
            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.wvalid && bus.wready) w_done = 1;
            @(posedge clk);
            #1;
        end
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                            output logic [31:0] data4, output logic [1:0] resp);
        bit ar_done;
        bit got;
        ar_done = 0;
        got = 0;
        data = 'x;
        data4 = 'x;
        resp = 2'bxx;
        bus.araddr = addr;
        for (int c = 0; c < 20 && !got; c++) begin
            bus.arvalid = !ar_done;
            bus.rready = 1'b0;
            if (bus.rvalid) begin
                bus.rready = 1'b1;
                data = bus.rdata;
                data4 = bus4.rdata;
                resp = bus.rresp;
                got = 1;
            end
            if (bus.arvalid && bus.arready) ar_done = 1;
            @(posedge clk);
            #1;
        end
        bus.arvalid = 1'b0;
        bus.rready = 1'b0;
    endtask

    // evt_a rise is sampled on one edge, evt_b rise exactly 'gap' edges later.
    task automatic pulse_events(input int gap);
        evt_a = 1'b1;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        evt_b = 1'b1;
        @(posedge clk);
        #1;
        evt_a = 1'b0;
        evt_b = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, rd4;
        logic [1:0]  rsp;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_handshake got=%b exp=00000",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        checks++;
        if (bus.rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_rdata got=%h exp=00000000", bus.rdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_irq got=%b exp=0", irq);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd, rd4, rsp);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_reg%0d got=%h exp=00000000", i, rd);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd, rd4;
        logic [1:0]  rsp;
        int          nb, bvc;
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h1, 32'h2, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, rsp, nb, bvc);
            checks++;
            if (rsp !== 2'b00 || nb !== 1) begin
                failures++;
                $display("[TB] FAIL wr_bresp%0d got=%b/%0d exp=00/1", i, rsp, nb);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd, rd4, rsp);
            checks++;
            if (rd !== exp_rd[i] || rsp !== 2'b00) begin
                failures++;
                $display("[TB] FAIL rd_reg%0d got=%h/%b exp=%h/00", i, rd, rsp, exp_rd[i]);
            end
        end
    endtask

    task automatic test_handshake_order();
        logic [31:0] rd, rd4;
        logic [1:0]  rsp;
        int          nb, bvc;
        axi_write(4'h4, 32'hA5A5_0001, 4'hF, 0, 3, 0, rsp, nb, bvc);
        checks++;
        if (nb !== 1 || bvc !== 1) begin
            failures++;
            $display("[TB] FAIL aw_first_bresp got=%0d/%0d exp=1/1", nb, bvc);
        end
        axi_read(4'h4, rd, rd4, rsp);
        checks++;
        if (rd !== 32'hA5A5_0001) begin
            failures++;
            $display("[TB] FAIL aw_first_data got=%h exp=a5a50001", rd);
        end
        axi_write(4'h4, 32'h5A5A_0002, 4'hF, 3, 0, 5, rsp, nb, bvc);
        checks++;
        if (nb !== 1 || bvc !== 6) begin
            failures++;
            $display("[TB] FAIL w_first_bhold got=%0d/%0d exp=1/6", nb, bvc);
        end
        axi_read(4'h4, rd, rd4, rsp);
        checks++;
        if (rd !== 32'h5A5A_0002) begin
            failures++;
            $display("[TB] FAIL w_first_data got=%h exp=5a5a0002", rd);
        end
    endtask

    task automatic test_wstrb();
        logic [31:0] rd, rd4;
        logic [1:0]  rsp;
        int          nb, bvc;
        axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, rsp, nb, bvc);
        axi_write(4'h4, 32'h0000_0000, 4'h2, 0, 0, 0, rsp, nb, bvc);
        axi_read(4'h4, rd, rd4, rsp);
        checks++;
        if (rd !== 32'hFFFF_00FF) begin
            failures++;
            $display("[TB] FAIL wstrb_byte1 got=%h exp=ffff00ff", rd);
        end
        axi_write(4'h8, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, rsp, nb, bvc);
        axi_read(4'h8, rd, rd4, rsp);
        checks++;
        if (rd !== 32'h0 || rsp !== 2'b00) begin
            failures++;
            $display("[TB] FAIL diff_ro got=%h/%b exp=00000000/00", rd, rsp);
        end
    endtask

    task automatic test_measure();
        logic [31:0] rd, rd4;
        logic [1:0]  rsp;
        int          nb, bvc;
        axi_write(4'h0, 32'h3, 4'hF, 0, 0, 0, rsp, nb, bvc);
        axi_read(4'hC, rd, rd4, rsp);
        checks++;
        if (rd !== 32'h4) begin
            failures++;
            $display("[TB] FAIL armed_busy got=%h exp=00000004", rd);
        end
        pulse_events(10);
        axi_read(4'h8, rd, rd4, rsp);
        checks++;
        if (rd !== 32'd10) begin
            failures++;
            $display("[TB] FAIL diff_10 got=%h exp=0000000a", rd);
        end
        axi_read(4'hC, rd, rd4, rsp);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("[TB] FAIL status_done got=%h exp=00000001", rd);
        end
        axi_write(4'hC, 32'h1, 4'hF, 0, 0, 0, rsp, nb, bvc);
        axi_read(4'hC, rd, rd4, rsp);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL status_w1c got=%h exp=00000000", rd);
        end
    endtask

    task automatic test_same_cycle_rise();
        logic [31:0] rd, rd4;
        logic [1:0]  rsp;
        int          nb, bvc;
        axi_write(4'h0, 32'h3, 4'hF, 0, 0, 0, rsp, nb, bvc);
        evt_a = 1'b1;
        evt_b = 1'b1;
        @(posedge clk);
        #1;
        evt_b = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        evt_b = 1'b1;
        @(posedge clk);
        #1;
        evt_a = 1'b0;
        evt_b = 1'b0;
        axi_read(4'h8, rd, rd4, rsp);
        checks++;
        if (rd !== 32'd5) begin
            failures++;
            $display("[TB] FAIL same_cycle_diff got=%h exp=00000005", rd);
        end
        axi_write(4'hC, 32'h3, 4'hF, 0, 0, 0, rsp, nb, bvc);
    endtask

    task automatic test_disable();
        logic [31:0] rd, rd4;
        logic [1:0]  rsp;
        int          nb, bvc;
        axi_write(4'h0, 32'h3, 4'hF, 0, 0, 0, rsp, nb, bvc);
        evt_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        evt_a = 1'b0;
        axi_write(4'h0, 32'h0, 4'hF, 0, 0, 0, rsp, nb, bvc);
        axi_read(4'hC, rd, rd4, rsp);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL disable_idle got=%h exp=00000000", rd);
        end
        axi_read(4'h8, rd, rd4, rsp);
        checks++;
        if (rd !== 32'd5) begin
            failures++;
            $display("[TB] FAIL disable_keeps_diff got=%h exp=00000005", rd);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd, rd4;
        logic [1:0]  rsp;
        int          nb, bvc;
        axi_write(4'h0, 32'h3, 4'hF, 0, 0, 0, rsp, nb, bvc);
        pulse_events(20);
        axi_read(4'h8, rd, rd4, rsp);
        checks++;
        if (rd !== 32'd20 || rd4 !== 32'hF) begin
            failures++;
            $display("[TB] FAIL ovf_diff got=%h/%h exp=00000014/0000000f", rd, rd4);
        end
        axi_read(4'hC, rd, rd4, rsp);
        checks++;
        if (rd !== 32'h1 || rd4 !== 32'h3) begin
            failures++;
            $display("[TB] FAIL ovf_status got=%h/%h exp=00000001/00000003", rd, rd4);
        end
        axi_write(4'hC, 32'h3, 4'hF, 0, 0, 0, rsp, nb, bvc);
        axi_read(4'hC, rd, rd4, rsp);
        checks++;
        if (rd4 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL ovf_w1c got=%h exp=00000000", rd4);
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd, rd4;
        logic [1:0]  rsp;
        int          nb, bvc;
        logic [31:0] exp_ctrl;
        exp_ctrl = IRQ_BUILD ? 32'h5 : 32'h1;
        axi_write(4'h0, 32'h7, 4'hF, 0, 0, 0, rsp, nb, bvc);
        axi_read(4'h0, rd, rd4, rsp);
        checks++;
        if (rd !== exp_ctrl) begin
            failures++;
            $display("[TB] FAIL ctrl_irq_en got=%h exp=%h", rd, exp_ctrl);
        end
        pulse_events(10);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irq_latency got=%b exp=0", irq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== IRQ_BUILD) begin
            failures++;
            $display("[TB] FAIL irq_assert got=%b exp=%b", irq, IRQ_BUILD);
        end
        axi_write(4'hC, 32'h1, 4'hF, 0, 0, 0, rsp, nb, bvc);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irq_clear got=%b exp=0", irq);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, rd4;
        logic [1:0]  rsp;
        int          nb, bvc;
        bus.awaddr = 4'h4;
        bus.awvalid = 1'b1;
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.awready !== 1'b1 || bus.bvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_slots got=%b%b exp=10", bus.awready, bus.bvalid);
        end
        axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, rsp, nb, bvc);
        checks++;
        if (nb !== 1) begin
            failures++;
            $display("[TB] FAIL rstmid_bresp got=%0d exp=1", nb);
        end
        axi_read(4'h4, rd, rd4, rsp);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL rstmid_scratch got=%h exp=00000000", rd);
        end
        axi_read(4'h0, rd, rd4, rsp);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("[TB] FAIL rstmid_ctrl got=%h exp=00000001", rd);
        end
    endtask

    initial begin
        bus.awaddr = '0;
        bus.awprot = '0;
        bus.awvalid = 1'b0;
        bus.wdata = '0;
        bus.wstrb = '0;
        bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0;
        bus.arprot = '0;
        bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        test_reset();
        test_write_read();
        test_handshake_order();
        test_wstrb();
        test_measure();
        test_same_cycle_rise();
        test_disable();
        test_overflow();
        test_irq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
